// File: rtl/axi_lite_regbank_pkg.sv
// axi_lite_regbank_pkg: response codes, FSM state types and byte-strobe merge for the register bank
package axi_lite_regbank_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    function automatic logic [31:0] merge_wstrb(input logic [31:0] old_v, input logic [31:0] new_v,
                                                input logic [3:0] strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8+:8] = strb[i] ? new_v[i*8+:8] : old_v[i*8+:8];
        return r;
    endfunction
endpackage

// File: rtl/axi_lite_regbank.sv
// axi_lite_regbank: AXI4-Lite slave register bank with read-only status slots and per-register access pulses
module axi_lite_regbank
    import axi_lite_regbank_pkg::*;
#(
    parameter int                     NUM_REGS     = 16,
    parameter int                     DATA_WIDTH   = 32,
    parameter int                     ADDR_WIDTH   = 40,
    parameter logic [NUM_REGS-1:0]    RO_MASK      = NUM_REGS'(3),
    parameter logic [NUM_REGS*32-1:0] RESET_VALUES = '0
) (
    input  logic                         axi_aclk,
    input  logic                         axi_reset,
    input  logic [ADDR_WIDTH-1:0]        s_axi_awaddr,
    input  logic [2:0]                   s_axi_awprot,
    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,
    input  logic [DATA_WIDTH-1:0]        s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]      s_axi_wstrb,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    output logic [1:0]                   s_axi_bresp,
    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
    input  logic [2:0]                   s_axi_arprot,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    output logic [DATA_WIDTH-1:0]        s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    output logic [NUM_REGS-1:0][31:0]    reg_out,
    input  logic [NUM_REGS-1:0][31:0]    reg_in,
    output logic [NUM_REGS-1:0]          wr_pulse,
    output logic [NUM_REGS-1:0]          rd_pulse
);
    localparam int IDX_W = $clog2(NUM_REGS);

    wr_state_t                  wr_state;
    rd_state_t                  rd_state;
    logic [NUM_REGS-1:0][31:0]  regs;
    logic                       live;
    logic [IDX_W-1:0]           aw_idx_q;
    logic [31:0]                wdata_q;
    logic [3:0]                 wstrb_q;
    logic                       aw_fire, w_fire, ar_fire, commit, c_ok, ar_ok;
    logic [IDX_W-1:0]           c_idx, ar_idx;
    logic [31:0]                c_data;
    logic [3:0]                 c_strb;
    logic                       unused;

    assign unused  = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr};
    assign aw_fire = s_axi_awvalid && s_axi_awready;
    assign w_fire  = s_axi_wvalid && s_axi_wready;
    assign ar_fire = s_axi_arvalid && s_axi_arready;
    // a ready that is low in W_IDLE means its beat is already latched
    assign commit  = live && wr_state == W_IDLE && (aw_fire || !s_axi_awready) && (w_fire || !s_axi_wready);
    assign c_idx   = aw_fire ? s_axi_awaddr[IDX_W+1:2] : aw_idx_q;
    assign c_data  = w_fire ? s_axi_wdata : wdata_q;
    assign c_strb  = w_fire ? s_axi_wstrb : wstrb_q;
    assign c_ok    = int'(c_idx) < NUM_REGS && !RO_MASK[c_idx];
    assign ar_idx  = s_axi_araddr[IDX_W+1:2];
    assign ar_ok   = int'(ar_idx) < NUM_REGS;

    always_comb
        for (int i = 0; i < NUM_REGS; i++) reg_out[i] = RO_MASK[i] ? '0 : regs[i];

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            wr_state      <= W_IDLE;
            live          <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            wr_pulse      <= '0;
            regs          <= RESET_VALUES;
            aw_idx_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
        end else begin
            live     <= 1'b1;
            wr_pulse <= '0;
            if (wr_state == W_IDLE) begin
                if (!live) begin
                    s_axi_awready <= 1'b1;
                    s_axi_wready  <= 1'b1;
                end
                if (aw_fire) begin
                    aw_idx_q      <= s_axi_awaddr[IDX_W+1:2];
                    s_axi_awready <= 1'b0;
                end
                if (w_fire) begin
                    wdata_q      <= s_axi_wdata;
                    wstrb_q      <= s_axi_wstrb;
                    s_axi_wready <= 1'b0;
                end
                if (commit) begin
                    if (c_ok) begin
                        regs[c_idx] <= merge_wstrb(regs[c_idx], c_data, c_strb);
                        wr_pulse    <= NUM_REGS'(1) << c_idx;
                    end
                    s_axi_bresp  <= c_ok ? RESP_OKAY : RESP_SLVERR;
                    s_axi_bvalid <= 1'b1;
                    wr_state     <= W_RESP;
                end
            end else if (s_axi_bready) begin
                s_axi_bvalid  <= 1'b0;
                s_axi_awready <= 1'b1;
                s_axi_wready  <= 1'b1;
                wr_state      <= W_IDLE;
            end
        end
    end

    // regs is sampled before this edge's write lands, so a colliding read sees the old value
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            rd_state      <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
            rd_pulse      <= '0;
        end else begin
            rd_pulse <= '0;
            if (rd_state == R_IDLE) begin
                s_axi_arready <= !ar_fire;
                if (ar_fire) begin
                    s_axi_rdata  <= !ar_ok ? '0 : RO_MASK[ar_idx] ? reg_in[ar_idx] : regs[ar_idx];
                    s_axi_rresp  <= ar_ok ? RESP_OKAY : RESP_SLVERR;
                    s_axi_rvalid <= 1'b1;
                    rd_pulse     <= ar_ok ? NUM_REGS'(1) << ar_idx : '0;
                    rd_state     <= R_DATA;
                end
            end else if (s_axi_rready) begin
                s_axi_rvalid  <= 1'b0;
                s_axi_arready <= 1'b1;
                rd_state      <= R_IDLE;
            end
        end
    end
endmodule
